// File: rtl/sdft_pkg.sv
// Shared types and defaults for the sliding-DFT bin sequencer.
package sdft_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int FFT_SIZE   = 512;
  localparam int IDX_W      = $clog2(FFT_SIZE);
  localparam int DISP_DECIM = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SWEEP
  } state_e;

  // Clamp a wide signed value into the signed range of a w-bit word (w <= 32).
  function automatic logic signed [32:0] saturate(input logic signed [32:0] v,
                                                  input int unsigned w);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sample_history_ram.sv
// Single-port sample ring storage: synchronous 1-cycle read, read-before-write.
module sample_history_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sdft_bin_sequencer.sv
// Sample intake, x[n]-x[n-N] difference and per-bin sweep feeding the sliding-DFT update.
//   state | meaning
//   IDLE  | ready for a sample (once out of reset)
//   LOAD  | oldest sample read from the ring
//   SWEEP | one bin per cycle, new sample written on bin 0
module sdft_bin_sequencer
  import sdft_pkg::*;
#(
  parameter int WORD_WIDTH = sdft_pkg::WORD_WIDTH,
  parameter int FFT_SIZE   = sdft_pkg::FFT_SIZE,
  parameter int DISP_DECIM = sdft_pkg::DISP_DECIM,
  localparam int BIN_W = $clog2(FFT_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [WORD_WIDTH-1:0] i_sample,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [BIN_W-1:0]             o_bin_addr,
  output logic signed [WORD_WIDTH-1:0] o_sample_diff,
  output logic [BIN_W-1:0]             o_idx,
  output logic                         o_wr_en,
  output logic                         o_disp_wr_en
);

  localparam int DW = (DISP_DECIM > 1) ? $clog2(DISP_DECIM) : 1;
  localparam logic [BIN_W-1:0] LAST_BIN   = BIN_W'(FFT_SIZE - 1);
  localparam logic [DW-1:0]    LAST_DECIM = DW'(DISP_DECIM - 1);
  localparam logic [BIN_W:0]   FILL_FULL  = (BIN_W + 1)'(FFT_SIZE);

  state_e                  state_q, state_d;
  logic                    run_q;
  logic [BIN_W-1:0]        bin_q;
  logic [BIN_W-1:0]        wr_ptr_q;
  logic [BIN_W:0]          fill_q;
  logic [DW-1:0]           decim_q;
  logic                    disp_q;
  logic signed [WORD_WIDTH-1:0] sample_q;
  logic signed [WORD_WIDTH-1:0] old_raw;
  logic signed [WORD_WIDTH-1:0] old_sample;
  logic signed [WORD_WIDTH:0]   diff_wide;
  logic signed [WORD_WIDTH-1:0] diff_sat;
  logic                    accept, ram_re, ram_we, sweep_last, fill_full;

  sample_history_ram #(
    .DEPTH(FFT_SIZE),
    .WIDTH(WORD_WIDTH)
  ) u_ring (
    .clk  (clk),
    .addr (wr_ptr_q),
    .we   (ram_we),
    .re   (ram_re),
    .wdata(sample_q),
    .rdata(old_raw)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    sweep_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid && run_q) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ram_re  = 1'b1;
        state_d = SWEEP;
      end
      SWEEP: begin
        ram_we = (bin_q == '0);
        if (bin_q == LAST_BIN) begin
          sweep_last = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ready    = run_q && (state_q == IDLE);
  assign o_bin_addr = bin_q;

  // Until the ring has been filled once, its contents are stale or undefined.
  assign fill_full  = (fill_q == FILL_FULL);
  assign old_sample = fill_full ? old_raw : '0;
  assign diff_wide  = {sample_q[WORD_WIDTH-1], sample_q} - {old_sample[WORD_WIDTH-1], old_sample};
  assign diff_sat   = WORD_WIDTH'(saturate(33'(diff_wide), WORD_WIDTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q         <= 1'b0;
      bin_q         <= '0;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      decim_q       <= '0;
      disp_q        <= 1'b0;
      sample_q      <= '0;
      o_idx         <= '0;
      o_sample_diff <= '0;
      o_wr_en       <= 1'b0;
      o_disp_wr_en  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        sample_q <= i_sample;
        disp_q   <= (decim_q == LAST_DECIM);
        decim_q  <= (decim_q == LAST_DECIM) ? '0 : decim_q + 1'b1;
      end
      if (state_q == SWEEP) bin_q <= sweep_last ? '0 : bin_q + 1'b1;
      if (sweep_last) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (!fill_full) fill_q <= fill_q + 1'b1;
      end
      // Sweep outputs lag o_bin_addr by one cycle to line up with ROM/RAM read data.
      o_wr_en       <= (state_q == SWEEP);
      o_idx         <= bin_q;
      o_sample_diff <= (state_q == SWEEP) ? diff_sat : '0;
      o_disp_wr_en  <= (state_q == SWEEP) && disp_q;
    end
  end

endmodule

// File: tb/tb_sdft_bin_sequencer.sv
// Directed bench for sdft_bin_sequencer with a small window (N=8) and display decimation of 4.
module tb_sdft_bin_sequencer;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int D  = 4;
  localparam int BW = $clog2(N);

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic signed [W-1:0] i_sample = '0;
  logic                i_valid = 1'b0;
  logic                o_ready;
  logic [BW-1:0]       o_bin_addr;
  logic signed [W-1:0] o_sample_diff;
  logic [BW-1:0]       o_idx;
  logic                o_wr_en;
  logic                o_disp_wr_en;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;

  sdft_bin_sequencer #(.WORD_WIDTH(W), .FFT_SIZE(N), .DISP_DECIM(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_sample     (i_sample),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_bin_addr   (o_bin_addr),
    .o_sample_diff(o_sample_diff),
    .o_idx        (o_idx),
    .o_wr_en      (o_wr_en),
    .o_disp_wr_en (o_disp_wr_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, o_wr_en, 0);
    check({tag, "_idx"}, o_idx, 0);
    check({tag, "_diff"}, o_sample_diff, 0);
    check({tag, "_disp"}, o_disp_wr_en, 0);
    check({tag, "_bin_addr"}, o_bin_addr, 0);
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    reset   = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    n_acc = 0;
    tick();
    check("ready_after_reset", o_ready, 1);
  endtask

  // Waits (bounded) for o_ready, then presents one sample for a single edge.
  task automatic send(input int val);
    int waited = 0;
    while (!o_ready && waited < 4 * N) begin
      tick();
      waited++;
    end
    check("ready_wait", o_ready, 1);
    i_sample = W'(val);
    i_valid  = 1'b1;
    tick();
    i_valid  = 1'b0;
  endtask

  // Entered in the LOAD cycle right after acceptance; walks the whole sweep.
  task automatic check_sweep(input logic signed [31:0] exp_diff, input logic exp_disp);
    check("ready_load", o_ready, 0);
    check("wr_en_load", o_wr_en, 0);
    tick();
    check("wr_en_sweep0", o_wr_en, 0);
    check("bin_addr_sweep0", o_bin_addr, 0);
    check("ready_sweep0", o_ready, 0);
    for (int k = 0; k < N; k++) begin
      tick();
      check("wr_en", o_wr_en, 1);
      check("idx", o_idx, k);
      check("diff", o_sample_diff, exp_diff);
      check("disp", o_disp_wr_en, exp_disp);
      check("bin_addr", o_bin_addr, (k < N - 1) ? k + 1 : 0);
      check("ready", o_ready, (k == N - 1) ? 1 : 0);
    end
    tick();
    check("wr_en_after", o_wr_en, 0);
    check("disp_after", o_disp_wr_en, 0);
  endtask

  task automatic send_chk(input int val, input int exp_diff);
    logic exp_disp;
    exp_disp = ((n_acc % D) == D - 1);
    n_acc++;
    send(val);
    check_sweep(exp_diff, exp_disp);
  endtask

  initial begin
    // Reset state
    repeat (5) tick();
    check("ready_in_reset", o_ready, 0);
    check_idle_outputs("reset");
    reset = 1'b1;
    check("ready_release_same_cycle", o_ready, 0);
    tick();
    check("ready_first_cycle", o_ready, 1);
    check("wr_en_first_cycle", o_wr_en, 0);

    // First sample during fill: diff equals the sample
    send_chk(100, 100);

    // Stream 1..N+2 from a clean ring; wrap makes sample N+1 see sample 1
    do_reset();
    for (int v = 1; v <= N; v++) send_chk(v, v);
    send_chk(N + 1, N);
    send_chk(N + 2, N);

    // Reset mid-sweep; stale ring data must be masked afterwards
    begin
      int waited = 0;
      n_acc++;
      send(N + 3);
      while (!(o_wr_en && o_idx == 5) && waited < 4 * N) begin
        tick();
        waited++;
      end
      check("reach_idx5", o_idx, 5);
      check("reach_idx5_diff", o_sample_diff, (N + 3) - 3);
      #2 reset = 1'b0;
      #1;
      check("ready_midreset", o_ready, 0);
      check_idle_outputs("midreset");
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      n_acc = 0;
      tick();
      check("ready_after_midreset", o_ready, 1);
      send_chk(77, 77);
    end

    // Saturation in both directions
    do_reset();
    send_chk(-32768, -32768);
    for (int i = 1; i < N; i++) send_chk(0, 0);
    send_chk(32767, 32767);
    for (int i = 1; i < N; i++) send_chk(0, 0);
    send_chk(-32768, -32768);

    // Backpressure: i_valid held high with data changing every cycle
    do_reset();
    for (int j = 0; j < 3 * (N + 2); j++) begin
      int m;
      int e;
      logic exp_wr;
      i_sample = W'(1000 + j);
      i_valid  = 1'b1;
      tick();
      m = j % (N + 2);
      e = j - m;
      exp_wr = (m >= 2) && (m <= N + 1);
      check("bp_wr_en", o_wr_en, exp_wr);
      check("bp_ready", o_ready, (m == N + 1) ? 1 : 0);
      check("bp_disp", o_disp_wr_en, 0);
      if (exp_wr) begin
        check("bp_idx", o_idx, m - 2);
        check("bp_diff", o_sample_diff, 1000 + e);
      end
    end
    i_valid = 1'b0;
    tick();
    check("bp_wr_en_end", o_wr_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
